// File: rtl/axis_frame_source.sv
// axis_frame_source
//
// Generates AXI4-Stream frames on command. Each accepted command describes
// one frame: cmd_len+1 beats whose data counts up from cmd_seed (wrapping),
// an optional bad-frame marker in tuser on the last beat, and a number of
// idle cycles to insert after the frame before the next command is taken.
//
// Ports
//   clk, rst          : clock (rising edge) and synchronous active-high reset
//   cmd_valid/ready   : command handshake; ready only while idle
//   cmd_len           : frame length in beats minus one
//   cmd_seed          : data of the first beat
//   cmd_gap           : idle cycles after the frame
//   cmd_bad           : mark the frame bad in tuser on its last beat
//   m_axis_*          : AXI4-Stream master (tdata/tkeep/tvalid/tlast/tuser, tready in)
//   busy              : a frame or its trailing gap is in progress
//   frame_done        : one-cycle pulse after the last beat handshake
//   frame_count       : completed frames, wrapping at 2^32
module axis_frame_source #(
  parameter int                    DATA_WIDTH           = 32,
  parameter int                    KEEP_WIDTH           = DATA_WIDTH / 8,
  parameter int                    LEN_WIDTH            = 16,
  parameter int                    GAP_WIDTH            = 8,
  parameter int                    USER_WIDTH           = 1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_seed,
  input  logic [GAP_WIDTH-1:0]  cmd_gap,
  input  logic                  cmd_bad,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,

  output logic                  busy,
  output logic                  frame_done,
  output logic [31:0]           frame_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                state_reg;
  state_t                state_next;

  logic [LEN_WIDTH-1:0]  len_reg;
  logic [LEN_WIDTH-1:0]  beat_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [GAP_WIDTH-1:0]  gap_reg;
  logic [GAP_WIDTH-1:0]  gap_cnt_reg;
  logic                  bad_reg;
  logic                  frame_done_reg;
  logic [31:0]           frame_count_reg;

  logic                  accept;
  logic                  handshake;
  logic                  beat_last;
  logic                  last_handshake;

  // The beat counter is compared against the latched length rather than
  // counting down, so a length of all ones runs the full 2^LEN_WIDTH beats
  // without the counter ever needing to wrap.
  assign beat_last      = (beat_reg == len_reg);
  assign accept         = cmd_valid && cmd_ready;
  assign handshake      = (state_reg == SEND) && m_axis_tready;
  assign last_handshake = handshake && beat_last;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      len_reg         <= '0;
      beat_reg        <= '0;
      data_reg        <= '0;
      gap_reg         <= '0;
      gap_cnt_reg     <= '0;
      bad_reg         <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      frame_done_reg <= last_handshake;

      // Command fields are captured once; later input changes are ignored
      // until the frame and its gap have finished.
      if (accept) begin
        len_reg  <= cmd_len;
        data_reg <= cmd_seed;
        beat_reg <= '0;
        gap_reg  <= cmd_gap;
        bad_reg  <= cmd_bad;
      end

      // Data only advances on non-last beats, so the last beat's data stays
      // on the bus while idle.
      if (handshake && !beat_last) begin
        data_reg <= data_reg + DATA_WIDTH'(1);
        beat_reg <= beat_reg + LEN_WIDTH'(1);
      end

      // Updated only on completion so the count holds its value otherwise.
      if (last_handshake) begin
        frame_count_reg <= frame_count_reg + 32'd1;
        gap_cnt_reg     <= gap_reg;
      end

      if (state_reg == GAP) begin
        gap_cnt_reg <= gap_cnt_reg - GAP_WIDTH'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (last_handshake) begin
          state_next = (gap_reg == '0) ? IDLE : GAP;
        end
      end
      GAP: begin
        // Entered with the counter equal to the gap length; leaving when it
        // reaches one gives exactly cmd_gap idle cycles.
        if (gap_cnt_reg == GAP_WIDTH'(1)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    cmd_ready     = (state_reg == IDLE) && !rst;
    busy          = (state_reg != IDLE);
    m_axis_tvalid = (state_reg == SEND);
    m_axis_tdata  = data_reg;
    m_axis_tlast  = (state_reg == SEND) && beat_last;
    m_axis_tuser  = '0;
    if ((state_reg == SEND) && beat_last && bad_reg) begin
      m_axis_tuser = USER_BAD_FRAME_VALUE;
    end
    frame_done    = frame_done_reg;
    frame_count   = frame_count_reg;
  end

  // Every byte lane is always valid.
  genvar gi;
  generate
    for (gi = 0; gi < KEEP_WIDTH; gi++) begin : g_keep
      assign m_axis_tkeep[gi] = 1'b1;
    end
  endgenerate

endmodule

// File: doc/axis_frame_source.md
AXIS_FRAME_SOURCE -- requirements
Module: axis_frame_source

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of m_axis_tdata, a multiple of 8.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8: width of m_axis_tkeep.
REQ-003 SHALL have parameter LEN_WIDTH, default 16: width of cmd_len.
REQ-004 SHALL have parameter GAP_WIDTH, default 8: width of cmd_gap.
REQ-005 SHALL have parameter USER_WIDTH, default 1: width of m_axis_tuser.
REQ-006 SHALL have parameter USER_BAD_FRAME_VALUE, default 1'b1: tuser value that marks a bad frame.
REQ-007 SHALL have port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-009 SHALL have port cmd_valid, input, 1 bit: a frame command is present.
REQ-010 SHALL have port cmd_ready, output, 1 bit: a command is accepted this cycle.
REQ-011 SHALL have port cmd_len, input, LEN_WIDTH bits: frame length in beats, minus one.
REQ-012 SHALL have port cmd_seed, input, DATA_WIDTH bits: data value of the first beat.
REQ-013 SHALL have port cmd_gap, input, GAP_WIDTH bits: idle cycles inserted after the frame.
REQ-014 SHALL have port cmd_bad, input, 1 bit: mark the frame as bad on its last beat.
REQ-015 SHALL have ports m_axis_tdata (DATA_WIDTH), m_axis_tkeep (KEEP_WIDTH), m_axis_tvalid (1), m_axis_tlast (1) and m_axis_tuser (USER_WIDTH), all outputs, plus m_axis_tready, input, 1 bit: the AXI4-Stream master port.
REQ-016 SHALL have port busy, output, 1 bit: a frame or gap is in progress.
REQ-017 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame completes.
REQ-018 SHALL have port frame_count, output, 32 bits: number of completed frames, wrapping.

Function
REQ-019 SHALL implement the states IDLE, SEND and GAP; busy = (state != IDLE).
REQ-020 SHALL drive cmd_ready high only in IDLE; a command is accepted on cmd_valid && cmd_ready, and cmd_len, cmd_seed, cmd_gap and cmd_bad are latched in that cycle.
REQ-021 SHALL, on accepting a command in cycle N, enter SEND and assert m_axis_tvalid in cycle N+1 with tdata = cmd_seed, i.e. a latency of 1 cycle.
REQ-022 SHALL make the beat at index i (0..cmd_len) carry tdata = (cmd_seed + i) mod 2^DATA_WIDTH; arithmetic wraps with no carry-out.
REQ-023 SHALL drive tkeep to all ones on every beat.
REQ-024 SHALL assert tlast only on beat index == cmd_len; cmd_len = 0 gives a single-beat frame with tlast high.
REQ-025 SHALL drive tuser to zero on non-last beats; on the last beat tuser = USER_BAD_FRAME_VALUE if cmd_bad is set, else zero.
REQ-026 SHALL advance a beat only on m_axis_tvalid && m_axis_tready.
REQ-027 SHALL, while m_axis_tvalid is high and m_axis_tready is low, hold tvalid, tdata, tlast and tuser stable, and SHALL never deassert tvalid before the handshake.
REQ-028 SHALL hold m_axis_tvalid high continuously within a frame (no bubbles) while in SEND.
REQ-029 SHALL, on the last-beat handshake in cycle T:
- pulse frame_done in cycle T+1;
- increment frame_count, visible in T+1, with wrap 0xFFFFFFFF -> 0;
- deassert tvalid in T+1;
- go to IDLE if cmd_gap == 0, else to GAP.
REQ-030 SHALL, in GAP, hold tvalid low for exactly cmd_gap cycles, then go to IDLE.
REQ-031 SHALL have a minimum spacing between frames of: last handshake T, IDLE/accept at T+1+cmd_gap, next first beat at T+2+cmd_gap.
REQ-032 SHALL ignore cmd_valid outside IDLE; an input change mid-frame SHALL not affect the frame in flight.
REQ-033 SHALL accept a cmd_len of all ones and produce 2^LEN_WIDTH beats; the beat counter SHALL not wrap early.

Reset
REQ-034 SHALL, when rst is high at a clock edge, on the next cycle set state = IDLE, m_axis_tvalid = 0, tlast = 0, tuser = 0, tdata = 0, frame_done = 0, frame_count = 0, busy = 0, and cmd_ready = 1 once rst is low.
REQ-035 SHALL let rst during SEND or GAP abandon the frame with no frame_done and no count increment; this is the only case in which tvalid drops before a handshake.
REQ-036 SHALL hold cmd_ready low while rst is high.

Verification
REQ-037 SHALL cover: tready held at 1, cmd len=3 seed=0x10 gap=0 bad=0 -> beats 0x10, 0x11, 0x12, 0x13 in 4 consecutive cycles starting N+1, tlast on 0x13 only, tuser=0, frame_done at N+5, frame_count=1.
REQ-038 SHALL cover: len=0 seed=0xFFFFFFFF bad=1 -> one beat, tdata=0xFFFFFFFF, tlast=1, tuser=1; then len=1 seed=0xFFFFFFFF -> beats 0xFFFFFFFF, 0x00000000.
REQ-039 SHALL cover: len=4 with tready toggling on a random pattern -> tdata/tlast stable whenever tvalid && !tready, 5 transfers in order, no tvalid gap before the last handshake.
REQ-040 SHALL cover: gap=3, second command presented continuously -> cmd_ready low for 3 cycles after the T+1 slot, accept at T+4, first beat of the second frame at T+5.
REQ-041 SHALL cover: rst asserted on beat 2 of an 8-beat frame -> tvalid=0, busy=0 and frame_count=0 the next cycle, no frame_done, and the next command restarts at its seed.
REQ-042 SHALL cover: frame_count preloaded via force to 0xFFFFFFFF, one frame -> frame_count=0 with a frame_done pulse.
